// File: rtl/shift_sweep_pkg.sv
// Shared definitions for the shift_sweep sequencer: FSM state encoding and
// width helpers for the shift-amount and beat-count fields.
package shift_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } sweep_state_e;

  localparam int SWEEP_BIT_DEFAULT = 8;

  function automatic int sweep_aw(input int bits);
    return $clog2(bits);
  endfunction

  // One extra bit so a full sweep of BIT beats (and beyond) is expressible.
  function automatic int sweep_cw(input int bits);
    return $clog2(bits) + 1;
  endfunction

endpackage

// File: rtl/shift_sweep_oreg.sv
// One-entry valid/ready output register for shifter result beats.
// Optional SHIFT_SWEEP_PARITY_EN adds a parity bit carried with each beat.
module shift_sweep_oreg #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic [AW-1:0] i_amt,
  input  logic          i_last,
`ifdef SHIFT_SWEEP_PARITY_EN
  input  logic          i_parity,
  output logic          o_parity,
`endif
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [AW-1:0] o_amt,
  output logic          o_last,
  output logic          o_can_load
);

  // A new beat may enter when the slot is empty or is being drained this cycle.
  assign o_can_load = !o_valid || i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_amt   <= '0;
      o_last  <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_amt   <= i_amt;
      o_last  <= i_last;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef SHIFT_SWEEP_PARITY_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_parity <= 1'b0;
    end else if (i_load) begin
      o_parity <= i_parity;
    end
  end
`endif

endmodule

// File: rtl/shift_sweep_ctrl.sv
// Sequencer driving a combinational barrel shifter with stepping shift amounts
// and streaming its results out. SHIFT_SWEEP_PARITY_EN adds o_out_parity.
module shift_sweep_ctrl
  import shift_sweep_pkg::*;
#(
  parameter  int BIT = SWEEP_BIT_DEFAULT,
  localparam int AW  = sweep_aw(BIT),
  localparam int CW  = sweep_cw(BIT)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_req_valid,
  output logic           o_req_ready,
  input  logic [BIT-1:0] i_req_data,
  input  logic           i_req_left,
  input  logic [AW-1:0]  i_req_amt,
  input  logic [CW-1:0]  i_req_count,
  output logic [BIT-1:0] o_shf_data,
  output logic           o_shf_left,
  output logic [AW-1:0]  o_shf_amt,
  input  logic [BIT-1:0] i_shf_result,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [BIT-1:0] o_out_data,
  output logic [AW-1:0]  o_out_amt,
  output logic           o_out_last,
  output logic           o_done
`ifdef SHIFT_SWEEP_PARITY_EN
  ,
  output logic           o_out_parity
`endif
);

  sweep_state_e  state, state_nxt;
  logic [CW-1:0] rem;
  logic [AW-1:0] amt_inc;
  logic          accept, load, done_nxt, can_load, rem_last;

  assign o_req_ready = (state == ST_IDLE);
  assign rem_last    = (rem == CW'(1));
  // Amounts wrap modulo BIT, which also covers non-power-of-two widths.
  assign amt_inc     = (o_shf_amt == AW'(BIT - 1)) ? '0 : o_shf_amt + AW'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req_valid) begin
          accept = 1'b1;
          if (i_req_count == '0) done_nxt  = 1'b1;
          else                   state_nxt = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (can_load) begin
          load = 1'b1;
          if (rem_last) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (o_out_valid && i_out_ready) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shifter drive: latched on accept, stepped on every captured beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_shf_data <= '0;
      o_shf_left <= 1'b0;
      o_shf_amt  <= '0;
      rem        <= '0;
    end else if (accept) begin
      o_shf_data <= i_req_data;
      o_shf_left <= i_req_left;
      o_shf_amt  <= i_req_amt;
      rem        <= i_req_count;
    end else if (load) begin
      o_shf_amt  <= amt_inc;
      rem        <= rem - CW'(1);
    end
  end

  shift_sweep_oreg #(
    .DW (BIT),
    .AW (AW)
  ) u_oreg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (load),
    .i_data     (i_shf_result),
    .i_amt      (o_shf_amt),
    .i_last     (rem_last),
`ifdef SHIFT_SWEEP_PARITY_EN
    .i_parity   (^i_shf_result),
    .o_parity   (o_out_parity),
`endif
    .i_ready    (i_out_ready),
    .o_valid    (o_out_valid),
    .o_data     (o_out_data),
    .o_amt      (o_out_amt),
    .o_last     (o_out_last),
    .o_can_load (can_load)
  );

endmodule
